// File: rtl/axi4_stream_drain_pkg.sv
// rtl/axi4_stream_drain_pkg.sv - shared enums and constants for the AXI4-Stream drain sink
package axi4_stream_drain_pkg;

  typedef enum logic [1:0] {
    RDY_ALWAYS   = 2'd0,
    RDY_PERIODIC = 2'd1,
    RDY_RANDOM   = 2'd2
  } rdy_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } pkt_state_e;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int ERR_W      = 3;
  localparam int ERR_DROP   = 0;
  localparam int ERR_CHANGE = 1;
  localparam int ERR_KEEP0  = 2;

endpackage

// File: rtl/axi4_stream_drain_rdy.sv
// rtl/axi4_stream_drain_rdy.sv - registered TREADY generator (always, periodic or LFSR pattern)
module axi4_stream_drain_rdy
  import axi4_stream_drain_pkg::*;
#(
  parameter int          RDY_MODE = 0,
  parameter int          RDY_ON   = 3,
  parameter int          RDY_OFF  = 1,
  parameter logic [15:0] RDY_SEED = 16'hACE1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_ready
);

  localparam int             PW     = $clog2(RDY_ON + RDY_OFF);
  localparam logic [PW-1:0]  ON_L   = PW'(RDY_ON);
  localparam logic [PW-1:0]  LAST_L = PW'(RDY_ON + RDY_OFF - 1);

  logic          r_started;
  logic [PW-1:0] r_phase;
  logic [15:0]   r_lfsr;
  logic          r_ready;
  logic [15:0]   w_lfsr_next;

  assign w_lfsr_next = {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
  assign o_ready     = r_ready;

  // r_started holds TREADY low for the first edge after reset release
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_started <= 1'b0;
      r_phase   <= '0;
      r_lfsr    <= RDY_SEED;
      r_ready   <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (r_started) begin
        r_phase <= (r_phase == LAST_L) ? '0 : r_phase + PW'(1);
        r_lfsr  <= w_lfsr_next;
        case (RDY_MODE)
          int'(RDY_PERIODIC): r_ready <= (r_phase < ON_L);
          int'(RDY_RANDOM):   r_ready <= w_lfsr_next[0];
          default:            r_ready <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: rtl/axi4_stream_drain.sv
// rtl/axi4_stream_drain.sv - AXI4-Stream sink with beat/byte/packet statistics and XOR checksum
// Optional protocol checker enabled by AXI4_STREAM_DRAIN_CHECK_EN.
module axi4_stream_drain
  import axi4_stream_drain_pkg::*;
#(
  parameter int          DW       = 32,
  parameter int          CW       = 32,
  parameter int          RDY_MODE = 0,
  parameter int          RDY_ON   = 3,
  parameter int          RDY_OFF  = 1,
  parameter logic [15:0] RDY_SEED = 16'hACE1
) (
  input  logic            ACLK,
  input  logic            ARESETn,
  input  logic            TVALID,
  output logic            TREADY,
  input  logic [DW-1:0]   TDATA,
  input  logic [DW/8-1:0] TKEEP,
  input  logic            TLAST,
  output logic [CW-1:0]   beat_cnt,
  output logic [CW-1:0]   byte_cnt,
  output logic [CW-1:0]   pkt_cnt,
  output logic [DW-1:0]   pkt_sum,
  output logic            pkt_vld,
  output logic [ERR_W-1:0] err
);

  localparam int KW = DW / 8;

  pkt_state_e    r_state;
  logic [CW-1:0] r_beat_cnt;
  logic [CW-1:0] r_byte_cnt;
  logic [CW-1:0] r_pkt_cnt;
  logic [DW-1:0] r_csum;
  logic [DW-1:0] r_pkt_sum;
  logic          r_pkt_vld;

  logic          w_accept;
  logic [DW-1:0] w_masked;
  logic [CW-1:0] w_pop;
  logic [DW-1:0] w_csum_next;

  axi4_stream_drain_rdy #(
    .RDY_MODE (RDY_MODE),
    .RDY_ON   (RDY_ON),
    .RDY_OFF  (RDY_OFF),
    .RDY_SEED (RDY_SEED)
  ) u_rdy (
    .i_clk   (ACLK),
    .i_rst_n (ARESETn),
    .o_ready (TREADY)
  );

  assign w_accept = TVALID & TREADY;

  always_comb begin
    w_masked = '0;
    w_pop    = '0;
    for (int i = 0; i < KW; i++) begin
      if (TKEEP[i]) begin
        w_masked[8*i +: 8] = TDATA[8*i +: 8];
        w_pop              = w_pop + CW'(1);
      end
    end
  end

  assign w_csum_next = r_csum ^ w_masked;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_byte_cnt <= '0;
      r_pkt_cnt  <= '0;
      r_csum     <= '0;
      r_pkt_sum  <= '0;
      r_pkt_vld  <= 1'b0;
    end else begin
      r_pkt_vld <= 1'b0;
      if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + CW'(1);
        r_byte_cnt <= r_byte_cnt + w_pop;
        if (TLAST) begin
          r_pkt_sum <= w_csum_next;
          r_pkt_cnt <= r_pkt_cnt + CW'(1);
          r_pkt_vld <= 1'b1;
          r_csum    <= '0;
        end else begin
          r_csum <= w_csum_next;
        end
        unique case (r_state)
          ST_IDLE: if (!TLAST) r_state <= ST_PKT;
          ST_PKT:  if (TLAST)  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign beat_cnt = r_beat_cnt;
  assign byte_cnt = r_byte_cnt;
  assign pkt_cnt  = r_pkt_cnt;
  assign pkt_sum  = r_pkt_sum;
  assign pkt_vld  = r_pkt_vld;

`ifdef AXI4_STREAM_DRAIN_CHECK_EN
  logic             r_stall;
  logic [DW-1:0]    r_hold_data;
  logic [KW-1:0]    r_hold_keep;
  logic             r_hold_last;
  logic [ERR_W-1:0] r_err;

  // Payload is sampled every cycle; only compared when the previous cycle stalled
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_stall     <= 1'b0;
      r_hold_data <= '0;
      r_hold_keep <= '0;
      r_hold_last <= 1'b0;
      r_err       <= '0;
    end else begin
      r_stall     <= TVALID & ~TREADY;
      r_hold_data <= TDATA;
      r_hold_keep <= TKEEP;
      r_hold_last <= TLAST;
      if (r_stall && !TVALID)
        r_err[ERR_DROP] <= 1'b1;
      if (r_stall && TVALID &&
          ({TDATA, TKEEP, TLAST} != {r_hold_data, r_hold_keep, r_hold_last}))
        r_err[ERR_CHANGE] <= 1'b1;
      if (w_accept && (TKEEP == '0))
        r_err[ERR_KEEP0] <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = '0;
`endif

endmodule

// File: tb/tb_axi4_stream_drain.sv
// tb/tb_axi4_stream_drain.sv - directed self-checking bench for axi4_stream_drain
module tb_axi4_stream_drain;

`ifdef AXI4_STREAM_DRAIN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // u0: mode 0, DW=32, CW=32
  logic v0, l0, rdy0, pv0;
  logic [31:0] d0, beat0, byte0, pcnt0, psum0;
  logic [3:0] k0;
  logic [2:0] err0;
  // u1: mode 1, ON=3, OFF=1
  logic v1, l1, rdy1, pv1;
  logic [31:0] d1, beat1, byte1, pcnt1, psum1;
  logic [3:0] k1;
  logic [2:0] err1;
  // u2: mode 0, CW=4
  logic v2, l2, rdy2, pv2;
  logic [31:0] d2, psum2;
  logic [3:0] k2, beat2, byte2, pcnt2;
  logic [2:0] err2;
  // u3: mode 2, DW=8
  logic v3, l3, rdy3, pv3;
  logic [7:0] d3, psum3;
  logic [0:0] k3;
  logic [31:0] beat3, byte3, pcnt3;
  logic [2:0] err3;

  axi4_stream_drain #(.DW(32), .CW(32), .RDY_MODE(0)) u0 (
    .ACLK(clk), .ARESETn(rst_n), .TVALID(v0), .TREADY(rdy0), .TDATA(d0), .TKEEP(k0),
    .TLAST(l0), .beat_cnt(beat0), .byte_cnt(byte0), .pkt_cnt(pcnt0), .pkt_sum(psum0),
    .pkt_vld(pv0), .err(err0));

  axi4_stream_drain #(.DW(32), .CW(32), .RDY_MODE(1), .RDY_ON(3), .RDY_OFF(1)) u1 (
    .ACLK(clk), .ARESETn(rst_n), .TVALID(v1), .TREADY(rdy1), .TDATA(d1), .TKEEP(k1),
    .TLAST(l1), .beat_cnt(beat1), .byte_cnt(byte1), .pkt_cnt(pcnt1), .pkt_sum(psum1),
    .pkt_vld(pv1), .err(err1));

  axi4_stream_drain #(.DW(32), .CW(4), .RDY_MODE(0)) u2 (
    .ACLK(clk), .ARESETn(rst_n), .TVALID(v2), .TREADY(rdy2), .TDATA(d2), .TKEEP(k2),
    .TLAST(l2), .beat_cnt(beat2), .byte_cnt(byte2), .pkt_cnt(pcnt2), .pkt_sum(psum2),
    .pkt_vld(pv2), .err(err2));

  axi4_stream_drain #(.DW(8), .CW(32), .RDY_MODE(2), .RDY_SEED(16'hACE1)) u3 (
    .ACLK(clk), .ARESETn(rst_n), .TVALID(v3), .TREADY(rdy3), .TDATA(d3), .TKEEP(k3),
    .TLAST(l3), .beat_cnt(beat3), .byte_cnt(byte3), .pkt_cnt(pcnt3), .pkt_sum(psum3),
    .pkt_vld(pv3), .err(err3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    v0 = 0; l0 = 0; d0 = '0; k0 = '0;
    v1 = 0; l1 = 0; d1 = '0; k1 = '0;
    v2 = 0; l2 = 0; d2 = '0; k2 = '0;
    v3 = 0; l3 = 0; d3 = '0; k3 = '0;
  endtask

  // Returns at 1 ns after the second edge following release
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [15:0] model_lfsr;
  int exp_beats;
  bit found;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    chk("reset_tready", rdy0, 0);
    chk("reset_beat", beat0, 0);
    chk("reset_sum", psum0, 0);
    chk("reset_vld", pv0, 0);
    chk("reset_err", err0, 0);
    rst_n = 1'b1;
    step();
    chk("tready_edge1", rdy0, 0);
    step();
    chk("tready_edge2", rdy0, 1);
    chk("tready_edge2_cw4", rdy2, 1);

    // 4-beat packet 1,2,4,8
    v0 = 1; k0 = 4'hF; d0 = 32'h1; step();
    d0 = 32'h2; step();
    d0 = 32'h4; step();
    d0 = 32'h8; l0 = 1;
    chk("vld_before_last", pv0, 0);
    step();
    v0 = 0; l0 = 0;
    chk("p4_beat", beat0, 4);
    chk("p4_byte", byte0, 16);
    chk("p4_pkt", pcnt0, 1);
    chk("p4_sum", psum0, 32'h0000000F);
    chk("p4_vld", pv0, 1);
    step();
    chk("p4_vld_drop", pv0, 0);
    chk("p4_sum_hold", psum0, 32'h0000000F);

    // All-zero TKEEP beat
    v0 = 1; d0 = 32'hFFFF_FFFF; k0 = 4'h0; step();
    v0 = 0;
    chk("k0_beat", beat0, 5);
    chk("k0_byte", byte0, 16);
    chk("k0_err", err0, CHK ? 3'b100 : 3'b000);

    // Single-beat packet, partial keep
    do_reset();
    v0 = 1; d0 = 32'hA5A5_A5A5; k0 = 4'h3; l0 = 1; step();
    v0 = 0; l0 = 0;
    chk("sb_byte", byte0, 2);
    chk("sb_sum", psum0, 32'h0000_A5A5);
    chk("sb_pkt", pcnt0, 1);
    chk("sb_vld", pv0, 1);
    chk("sb_err", err0, 0);

    // Reset in the middle of a packet
    do_reset();
    v0 = 1; k0 = 4'hF; d0 = 32'h1; step();
    d0 = 32'h2; step();
    v0 = 0;
    chk("mid_beat", beat0, 2);
    rst_n = 1'b0;
    #1;
    chk("async_beat", beat0, 0);
    chk("async_byte", byte0, 0);
    chk("async_tready", rdy0, 0);
    do_reset();
    v0 = 1; d0 = 32'h1234_5678; k0 = 4'hF; l0 = 1; step();
    v0 = 0; l0 = 0;
    chk("post_rst_pkt", pcnt0, 1);
    chk("post_rst_sum", psum0, 32'h1234_5678);
    chk("post_rst_beat", beat0, 1);

    // CW=4 wrap coinciding with packet end on beat 16
    do_reset();
    v2 = 1; k2 = 4'hF;
    for (int i = 1; i <= 16; i++) begin
      d2 = 32'(i);
      l2 = (i == 16);
      step();
    end
    chk("wrap_beat", beat2, 0);
    chk("wrap_byte", byte2, 0);
    chk("wrap_pkt", pcnt2, 1);
    chk("wrap_sum", psum2, 32'h10);
    chk("wrap_vld", pv2, 1);
    l2 = 0; d2 = 32'd17; step();
    v2 = 0;
    chk("wrap17_beat", beat2, 1);
    chk("wrap17_byte", byte2, 4);
    chk("wrap17_vld", pv2, 0);
    chk("wrap_err", err2, 0);

    // Periodic backpressure, TVALID held for 40 cycles
    do_reset();
    v1 = 1; d1 = 32'hC0FF_EE00; k1 = 4'hF;
    for (int i = 0; i < 40; i++) begin
      chk("rdy_periodic", rdy1, ((i % 4) != 3));
      step();
    end
    v1 = 0;
    chk("per_beat", beat1, 30);
    chk("per_byte", byte1, 120);
    chk("per_pkt", pcnt1, 0);
    chk("per_sum", psum1, 0);
    chk("per_vld", pv1, 0);
    chk("per_err", err1, 0);

    // Protocol violations under periodic backpressure
    do_reset();
    v1 = 1; d1 = 32'h1111_1111; k1 = 4'hF;
    found = 0;
    for (int n = 0; n < 10; n++) begin
      if (rdy1 === 1'b0) begin found = 1; break; end
      step();
    end
    chk("wait_stall1", found, 1);
    step();
    d1 = 32'h2222_2222;
    step();
    chk("err_change", err1, CHK ? 3'b010 : 3'b000);
    found = 0;
    for (int n = 0; n < 10; n++) begin
      if (rdy1 === 1'b0) begin found = 1; break; end
      step();
    end
    chk("wait_stall2", found, 1);
    chk("err_change_sticky", err1, CHK ? 3'b010 : 3'b000);
    step();
    v1 = 0;
    step();
    chk("err_drop", err1, CHK ? 3'b011 : 3'b000);
    repeat (3) step();
    chk("err_drop_sticky", err1, CHK ? 3'b011 : 3'b000);

    // LFSR backpressure on an 8-bit stream
    do_reset();
    model_lfsr = lfsr_adv(16'hACE1);
    exp_beats = 0;
    v3 = 1; d3 = 8'h5A; k3 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("rdy_lfsr", rdy3, model_lfsr[0]);
      if (model_lfsr[0]) exp_beats++;
      step();
      model_lfsr = lfsr_adv(model_lfsr);
    end
    v3 = 0;
    chk("lfsr_beat", beat3, 32'(exp_beats));
    chk("lfsr_byte", byte3, 32'(exp_beats));
    chk("lfsr_pkt", pcnt3, 0);
    chk("lfsr_sum", psum3, 0);
    chk("lfsr_vld", pv3, 0);
    chk("lfsr_err", err3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
